multdiv_controller: RTL and testbench

Sequencing controller for the shared multi-cycle multiply/divide unit in the pipelined processor. Accepts one mult/div operation at a time from the execute stage, starts the unit, counts its fixed latency, and holds the completed result for writeback until it is accepted. Tracks the in-flight destination register and raises a decode-stage stall for any instruction that depends on it, or that needs the unit while it is busy.

---
 rtl/multdiv_controller.sv | 122 ++++++++++++
 tb/tb_multdiv_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_controller.sv
// Sequencing controller for the shared multi-cycle multiply/divide unit:
// issue handshake, fixed-latency run timer, writeback hold and hazard stall.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no op in flight, ready to accept
// S_RUN  | unit started, latency down-counter running
// S_DONE | result held for writeback until wb_accept (or flush)
module multdiv_controller #(
  parameter int MULT_CYCLES = 16,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       issue_valid,
  input  logic       issue_is_div,
  input  logic [4:0] issue_rd,
  output logic       issue_ready,
  output logic       unit_start_mult,
  output logic       unit_start_div,
  output logic       unit_abort,
  input  logic       unit_exception,
  input  logic       flush,
  output logic       wb_valid,
  input  logic       wb_accept,
  output logic [4:0] wb_rd,
  output logic       wb_exception,
  input  logic [4:0] fd_rs1,
  input  logic [4:0] fd_rs2,
  input  logic [4:0] fd_rd,
  input  logic       fd_is_multdiv,
  output logic       busy,
  output logic [4:0] busy_rd,
  output logic       stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    busy_rd_q;
  logic [4:0]    wb_rd_q;
  logic          wb_exc_q;
  logic          start_mult_q;
  logic          start_div_q;
  logic          abort_q;

  logic accept;
  logic dep;

  assign issue_ready = (state_q == S_IDLE) |
                       ((state_q == S_DONE) & (wb_accept | flush));
  assign accept      = issue_valid & issue_ready & ~flush;

  // Register 0 is hardwired, so it never creates a hazard.
  assign dep   = (busy_rd_q != 5'd0) &
                 ((fd_rs1 == busy_rd_q) | (fd_rs2 == busy_rd_q) | (fd_rd == busy_rd_q));
  assign busy  = (state_q != S_IDLE);
  assign stall = (busy & dep) | (fd_is_multdiv & ~issue_ready);

  assign unit_start_mult = start_mult_q;
  assign unit_start_div  = start_div_q;
  assign unit_abort      = abort_q;
  assign wb_valid        = (state_q == S_DONE);
  assign wb_rd           = wb_rd_q;
  assign wb_exception    = wb_exc_q;
  assign busy_rd         = busy_rd_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      busy_rd_q    <= 5'd0;
      wb_rd_q      <= 5'd0;
      wb_exc_q     <= 1'b0;
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      abort_q      <= 1'b0;
      if (flush) begin
        abort_q <= (state_q == S_RUN);
        state_q <= S_IDLE;
      end else if (accept) begin
        // Covers both IDLE issue and the back-to-back DONE+wb_accept case.
        state_q      <= S_RUN;
        cnt_q        <= issue_is_div ? DIV_LOAD : MULT_LOAD;
        busy_rd_q    <= issue_rd;
        start_mult_q <= ~issue_is_div;
        start_div_q  <= issue_is_div;
      end else begin
        case (state_q)
          S_RUN: begin
            if (cnt_q == '0) begin
              wb_exc_q <= unit_exception;
              wb_rd_q  <= busy_rd_q;
              state_q  <= S_DONE;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_DONE: begin
            if (wb_accept) state_q <= S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_controller.sv
// Bench for multdiv_controller: directed scenarios then random traffic, all
// cycles compared against a timestamp-based model of the in-flight op.
module tb_multdiv_controller;

  localparam int MULTC = 16;
  localparam int DIVC  = 32;

  logic       clock;
  logic       reset;
  logic       issue_valid;
  logic       issue_is_div;
  logic [4:0] issue_rd;
  logic       issue_ready;
  logic       unit_start_mult;
  logic       unit_start_div;
  logic       unit_abort;
  logic       unit_exception;
  logic       flush;
  logic       wb_valid;
  logic       wb_accept;
  logic [4:0] wb_rd;
  logic       wb_exception;
  logic [4:0] fd_rs1;
  logic [4:0] fd_rs2;
  logic [4:0] fd_rd;
  logic       fd_is_multdiv;
  logic       busy;
  logic [4:0] busy_rd;
  logic       stall;

  multdiv_controller #(.MULT_CYCLES(MULTC), .DIV_CYCLES(DIVC)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .unit_start_mult(unit_start_mult), .unit_start_div(unit_start_div),
    .unit_abort(unit_abort), .unit_exception(unit_exception), .flush(flush),
    .wb_valid(wb_valid), .wb_accept(wb_accept), .wb_rd(wb_rd),
    .wb_exception(wb_exception),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rd(fd_rd), .fd_is_multdiv(fd_is_multdiv),
    .busy(busy), .busy_rd(busy_rd), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Model: an op is described by its destination, kind and the cycle in
  // which it started running; completion time follows from the latency.
  int         cyc;
  bit         m_have;
  bit         m_div;
  int         m_start;
  logic [4:0] m_busy_rd;
  logic [4:0] m_wb_rd;
  logic       m_wb_exc;
  logic       m_sm, m_sd, m_ab;
  bit         m_fresh;
  bit         exc_drive;
  bit         exc_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic tick();
    int lat;
    bit idle, run, done, last, ready, acc, dep, stl;
    lat  = m_div ? DIVC : MULTC;
    idle = !m_have;
    done = m_have && (cyc >= m_start + lat);
    run  = m_have && !done;
    last = run && (cyc == m_start + lat - 1);
    if (exc_drive) unit_exception = last ? exc_val : ~exc_val;
    #1;
    ready = idle | (done & (wb_accept | flush));
    dep   = (m_busy_rd != 5'd0) &&
            ((fd_rs1 == m_busy_rd) || (fd_rs2 == m_busy_rd) || (fd_rd == m_busy_rd));
    stl   = (m_have & dep) | (fd_is_multdiv & !ready);
    chk("issue_ready", 32'(issue_ready), 32'(ready));
    chk("stall", 32'(stall), 32'(stl));
    chk("busy", 32'(busy), 32'(m_have));
    chk("wb_valid", 32'(wb_valid), 32'(done));
    chk("start_mult", 32'(unit_start_mult), 32'(m_sm));
    chk("start_div", 32'(unit_start_div), 32'(m_sd));
    chk("abort", 32'(unit_abort), 32'(m_ab));
    if (m_have || m_fresh) chk("busy_rd", 32'(busy_rd), 32'(m_busy_rd));
    if (done || m_fresh) begin
      chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
      chk("wb_exception", 32'(wb_exception), 32'(m_wb_exc));
    end
    acc = issue_valid & ready & !flush;
    if (!reset) begin
      m_have = 0; m_busy_rd = 0; m_wb_rd = 0; m_wb_exc = 0;
      m_sm = 0; m_sd = 0; m_ab = 0; m_fresh = 1;
    end else begin
      m_sm = acc & !issue_is_div;
      m_sd = acc & issue_is_div;
      m_ab = flush & run;
      if (last && !flush) begin
        m_wb_rd  = m_busy_rd;
        m_wb_exc = unit_exception;
      end
      if (flush) m_have = 0;
      else if (acc) begin
        m_have = 1; m_start = cyc + 1; m_div = issue_is_div;
        m_busy_rd = issue_rd; m_fresh = 0;
      end else if (done && wb_accept) m_have = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    issue_valid = 0; issue_is_div = 0; issue_rd = 0; flush = 0; wb_accept = 0;
    fd_rs1 = 5'd20; fd_rs2 = 5'd21; fd_rd = 5'd22; fd_is_multdiv = 0;
  endtask

  task automatic issue(input bit is_div, input logic [4:0] rd);
    issue_valid = 1; issue_is_div = is_div; issue_rd = rd;
    tick();
    issue_valid = 0;
  endtask

  initial begin
    reset = 0; unit_exception = 0; exc_drive = 0; exc_val = 0;
    quiet();
    repeat (2) @(posedge clock);
    #1;
    cyc = 0; m_have = 0; m_div = 0; m_start = 0; m_busy_rd = 0; m_wb_rd = 0;
    m_wb_exc = 0; m_sm = 0; m_sd = 0; m_ab = 0; m_fresh = 1;
    tick();
    reset = 1;
    tick();

    // Multiply rd=5: start pulse once, result after 16 cycles, held until accept.
    issue(1'b0, 5'd5);
    chk("mult_start_c1", 32'(unit_start_mult), 32'd1);
    chk("mult_busy_rd", 32'(busy_rd), 32'd5);
    tick();
    chk("mult_start_c2", 32'(unit_start_mult), 32'd0);
    repeat (14) tick();
    chk("mult_valid_c16", 32'(wb_valid), 32'd0);
    tick();
    chk("mult_valid_c17", 32'(wb_valid), 32'd1);
    chk("mult_wb_rd", 32'(wb_rd), 32'd5);
    repeat (3) tick();
    chk("mult_hold_c20", 32'(wb_valid), 32'd1);
    wb_accept = 1;
    tick();
    wb_accept = 0;
    chk("mult_idle_c21", 32'(busy), 32'd0);
    tick();

    // Divide rd=9, exception only on the last RUN cycle.
    exc_drive = 1; exc_val = 1;
    issue(1'b1, 5'd9);
    chk("div_start", 32'(unit_start_div), 32'd1);
    repeat (31) tick();
    chk("div_valid_c32", 32'(wb_valid), 32'd0);
    tick();
    chk("div_valid_c33", 32'(wb_valid), 32'd1);
    chk("div_exc", 32'(wb_exception), 32'd1);
    chk("div_wb_rd", 32'(wb_rd), 32'd9);
    wb_accept = 1;
    tick();
    wb_accept = 0;
    exc_drive = 0; unit_exception = 0;

    // Hazard stalls against busy_rd=7, then flush in RUN cycle 5.
    issue(1'b0, 5'd7);
    fd_rs2 = 5'd7;
    #1 chk("stall_rs2_dep", 32'(stall), 32'd1);
    tick();
    fd_rs2 = 5'd21; fd_is_multdiv = 1;
    #1 chk("stall_unit_busy", 32'(stall), 32'd1);
    tick();
    fd_is_multdiv = 0;
    #1 chk("stall_none", 32'(stall), 32'd0);
    repeat (2) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush_abort", 32'(unit_abort), 32'd1);
    chk("flush_idle", 32'(busy), 32'd0);
    repeat (20) tick();

    // rd=0 never creates a dependency; its result still handshakes.
    issue(1'b0, 5'd0);
    fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_rd = 5'd0;
    #1 chk("stall_rd0", 32'(stall), 32'd0);
    repeat (16) tick();
    chk("rd0_valid", 32'(wb_valid), 32'd1);

    // Back-to-back: accept result and issue mult rd=3 in the same cycle.
    wb_accept = 1; issue_valid = 1; issue_is_div = 0; issue_rd = 5'd3;
    tick();
    quiet();
    chk("b2b_valid_low", 32'(wb_valid), 32'd0);
    chk("b2b_busy_rd", 32'(busy_rd), 32'd3);
    chk("b2b_start", 32'(unit_start_mult), 32'd1);
    flush = 1;
    tick();
    // Flush together with an issue while IDLE: issue ignored.
    issue_valid = 1; issue_is_div = 1; issue_rd = 5'd4;
    tick();
    quiet();
    chk("flush_idle_nostart", 32'(unit_start_div), 32'd0);
    chk("flush_idle_busy", 32'(busy), 32'd0);
    tick();

    // Reset in cycle 10 of a divide.
    issue(1'b1, 5'd12);
    repeat (9) tick();
    reset = 0;
    tick();
    reset = 1;
    fd_rs1 = 5'd12; fd_is_multdiv = 1;
    #1;
    chk("rst_ready", 32'(issue_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_busy_rd", 32'(busy_rd), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_start", 32'({unit_start_mult, unit_start_div, unit_abort}), 32'd0);
    tick();
    quiet();

    // Random traffic.
    exc_drive = 1;
    for (int i = 0; i < 1500; i++) begin
      issue_valid   = ($urandom_range(0, 2) != 0);
      issue_is_div  = $urandom_range(0, 1) == 1;
      issue_rd      = 5'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 60) == 0);
      wb_accept     = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 300) != 0);
      fd_rs1        = 5'($urandom_range(0, 7));
      fd_rs2        = 5'($urandom_range(0, 7));
      fd_rd         = 5'($urandom_range(0, 7));
      fd_is_multdiv = $urandom_range(0, 1) == 1;
      exc_val       = $urandom_range(0, 1) == 1;
      tick();
    end
    reset = 1;
    quiet();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
